dco_phase_accum: RTL and testbench

Parametrised fixed-point DCO phase-accumulator model for the control loop. Once per refclk edge it adds a frequency-control-dependent phase increment to a wrapped phase register and reports sampled phase in half-stage units. Compared with the first-generation control-only model, it adds:
- integer (synthesisable) arithmetic;
- clamping of the control word;
- an enable/settle state machine with a valid flag;
- configurable ring-stage count and fractional resolution.

It sits between the digital loop filter (`dctrl` source) and the phase detector/TDC model.

---
 rtl/dco_phase_accum_pkg.sv | 22 ++
 rtl/dco_phase_accum_if.sv | 17 +
 rtl/dco_phase_accum_inc_calc.sv | 61 ++++++
 rtl/dco_phase_accum.sv | 122 ++++++++++++
 tb/tb_dco_phase_accum.sv | 110 +++++++++++
 5 files changed

// File: rtl/dco_phase_accum_pkg.sv
// Shared types, width helpers and 100 MHz-reference defaults for the DCO phase-accumulator model.
package dco_model_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } dco_state_e;

  // F0 is 40.0 DCO cycles per ref edge in Q16.16, i.e. 4 GHz at a 100 MHz reference.
  localparam longint F0_WORD_100M   = 64'd2621440;
  localparam int     KDCO_WORD_100M = 3;

  function automatic int acc_width(int int_w, int frac_w);
    return int_w + frac_w;
  endfunction

  function automatic int ph_width(int int_w, int num_stages);
    return int_w + $clog2(2 * num_stages);
  endfunction

endpackage

// File: rtl/dco_phase_accum_if.sv
// Control-in / phase-out bundle between the loop filter, the DCO model and the TDC model.
interface dco_phase_accum_if #(
  parameter int DCTRL_W = 12,
  parameter int ACC_W   = 32,
  parameter int PH_W    = 19
);
  logic                      en;
  logic signed [DCTRL_W-1:0] dctrl;
  logic [ACC_W-1:0]          phase_acc;
  logic [PH_W-1:0]           dco_phase;
  logic [ACC_W-1:0]          phase_inc;
  logic                      valid;
  logic                      sat;

  modport master (output en, dctrl, input phase_acc, dco_phase, phase_inc, valid, sat);
  modport slave  (input en, dctrl, output phase_acc, dco_phase, phase_inc, valid, sat);
endinterface

// File: rtl/dco_phase_accum_inc_calc.sv
// Control word to phase increment: clamp dctrl, apply F0 + KDCO*dctrl, floor at 0, clip to ACC_W.
module dco_inc_calc #(
  parameter int     DCTRL_W   = 12,
  parameter int     ACC_W     = 32,
  parameter longint F0_WORD   = 2621440,
  parameter int     KDCO_WORD = 3,
  parameter int     DCTRL_MIN = -1000,
  parameter int     DCTRL_MAX = 1000
) (
  input  logic signed [DCTRL_W-1:0] dctrl,
  output logic [ACC_W-1:0]          inc,
  output logic                      sat
);

  localparam int W = ACC_W + DCTRL_W + 2;

  localparam logic signed [W-1:0] MIN_X   = W'(DCTRL_MIN);
  localparam logic signed [W-1:0] MAX_X   = W'(DCTRL_MAX);
  localparam logic signed [W-1:0] F0_X    = W'(F0_WORD);
  localparam logic signed [W-1:0] K_X     = W'(KDCO_WORD);
  localparam logic signed [W-1:0] INC_MAX = (W'(1) << ACC_W) - W'(1);

  logic signed [W-1:0] dctrl_x;
  logic signed [W-1:0] dsat_x;
  logic signed [W-1:0] inc_raw;
  logic signed [W-1:0] inc_c;
  logic                clamp_hit;
  logic                range_hit;

  assign dctrl_x = W'(dctrl);

  always_comb begin
    dsat_x    = dctrl_x;
    clamp_hit = 1'b0;
    if (dctrl_x < MIN_X) begin
      dsat_x    = MIN_X;
      clamp_hit = 1'b1;
    end else if (dctrl_x > MAX_X) begin
      dsat_x    = MAX_X;
      clamp_hit = 1'b1;
    end
  end

  assign inc_raw = F0_X + K_X * dsat_x;

  always_comb begin
    inc_c     = inc_raw;
    range_hit = 1'b0;
    if (inc_raw < 0) begin
      inc_c     = '0;
      range_hit = 1'b1;
    end else if (inc_raw > INC_MAX) begin
      inc_c     = INC_MAX;
      range_hit = 1'b1;
    end
  end

  assign inc = inc_c[ACC_W-1:0];
  assign sat = clamp_hit | range_hit;

endmodule

// File: rtl/dco_phase_accum.sv
// Fixed-point DCO phase accumulator with enable/settle FSM; reports wrapped phase in half-stage units.
module dco_phase_accum
  import dco_model_pkg::*;
#(
  parameter int     DCTRL_W    = 12,
  parameter int     INT_W      = 16,
  parameter int     FRAC_W     = 16,
  parameter int     NUM_STAGES = 4,
  parameter longint F0_WORD    = F0_WORD_100M,
  parameter int     KDCO_WORD  = KDCO_WORD_100M,
  parameter int     DCTRL_MIN  = -1000,
  parameter int     DCTRL_MAX  = 1000,
  parameter int     SETTLE_CYC = 2
) (
  input  logic             refclk,
  input  logic             resetn,
  dco_phase_accum_if.slave bus
);

  localparam int ACC_W = acc_width(INT_W, FRAC_W);
  localparam int PH_W  = ph_width(INT_W, NUM_STAGES);
  localparam int L     = $clog2(2 * NUM_STAGES);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (SETTLE_CYC > 0) ? CNT_W'(SETTLE_CYC - 1) : '0;

  dco_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] phase_acc_q, phase_acc_d;
  logic [PH_W-1:0]  dco_phase_q, dco_phase_d;
  logic [ACC_W-1:0] phase_inc_q, phase_inc_d;
  logic             valid_q, valid_d;
  logic             sat_q, sat_d;

  logic [ACC_W-1:0]   inc;
  logic               inc_sat;
  logic               accum;
  logic [ACC_W+L-1:0] scaled;

  dco_inc_calc #(
    .DCTRL_W  (DCTRL_W),
    .ACC_W    (ACC_W),
    .F0_WORD  (F0_WORD),
    .KDCO_WORD(KDCO_WORD),
    .DCTRL_MIN(DCTRL_MIN),
    .DCTRL_MAX(DCTRL_MAX)
  ) u_inc (
    .dctrl(bus.dctrl),
    .inc  (inc),
    .sat  (inc_sat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_acc_d = phase_acc_q;
    dco_phase_d = dco_phase_q;
    phase_inc_d = phase_inc_q;
    valid_d     = valid_q;
    sat_d       = sat_q;
    accum       = 1'b0;
    scaled      = '0;
    if (!bus.en) begin
      state_d     = IDLE;
      cnt_d       = '0;
      phase_acc_d = '0;
      dco_phase_d = '0;
      phase_inc_d = '0;
      valid_d     = 1'b0;
      sat_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = (SETTLE_CYC > 0) ? SETTLE : RUN;
          cnt_d   = '0;
        end
        SETTLE: begin
          accum = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_d = RUN;
        end
        RUN:     accum = 1'b1;
        default: state_d = IDLE;
      endcase
      if (accum) begin
        phase_acc_d = phase_acc_q + inc;
        phase_inc_d = inc;
        sat_d       = inc_sat;
        // 2*NUM_STAGES is a power of two, so the scale is a shift and wraps with phase_acc.
        scaled      = {phase_acc_d, {L{1'b0}}};
        dco_phase_d = scaled[ACC_W+L-1:FRAC_W];
        valid_d     = (state_d == RUN);
      end
    end
  end

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_acc_q <= '0;
      dco_phase_q <= '0;
      phase_inc_q <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_acc_q <= phase_acc_d;
      dco_phase_q <= dco_phase_d;
      phase_inc_q <= phase_inc_d;
      valid_q     <= valid_d;
      sat_q       <= sat_d;
    end
  end

  assign bus.phase_acc = phase_acc_q;
  assign bus.dco_phase = dco_phase_q;
  assign bus.phase_inc = phase_inc_q;
  assign bus.valid     = valid_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_dco_phase_accum.sv
// Directed bench for dco_phase_accum: defaults, low-F0 floor, and narrow-INT_W wrap instances.
module tb_dco_phase_accum;

  logic refclk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 refclk = ~refclk;

  dco_phase_accum_if #(.DCTRL_W(12), .ACC_W(32), .PH_W(19)) b0 ();
  dco_phase_accum_if #(.DCTRL_W(12), .ACC_W(32), .PH_W(19)) b1 ();
  dco_phase_accum_if #(.DCTRL_W(12), .ACC_W(24), .PH_W(11)) b2 ();

  dco_phase_accum u_d0 (.refclk(refclk), .resetn(resetn), .bus(b0));
  dco_phase_accum #(.F0_WORD(100)) u_d1 (.refclk(refclk), .resetn(resetn), .bus(b1));
  dco_phase_accum #(.INT_W(8), .SETTLE_CYC(0)) u_d2 (.refclk(refclk), .resetn(resetn), .bus(b2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic [31:0] acc, input logic v,
                      input logic [18:0] ph, input logic [31:0] inc, input logic s);
    chk({tag, ".acc"}, b0.phase_acc, acc);
    chk({tag, ".valid"}, b0.valid, v);
    chk({tag, ".phase"}, b0.dco_phase, ph);
    chk({tag, ".inc"}, b0.phase_inc, inc);
    chk({tag, ".sat"}, b0.sat, s);
  endtask

  task automatic settle_seq(input string tag);
    step(); chk0({tag, ".e0"}, 0, 0, 0, 0, 0);
    step(); chk0({tag, ".e1"}, 32'd2621440, 0, 19'd320, 32'd2621440, 0);
    step(); chk0({tag, ".e2"}, 32'd5242880, 1, 19'd640, 32'd2621440, 0);
  endtask

  initial begin
    resetn   = 1'b0;
    b0.en    = 1'b0; b0.dctrl = '0;
    b1.en    = 1'b0; b1.dctrl = '0;
    b2.en    = 1'b0; b2.dctrl = '0;
    step(); step();
    chk0("reset", 0, 0, 0, 0, 0);
    resetn = 1'b1;

    b0.en = 1'b1;
    settle_seq("s1");

    b0.dctrl = 12'sd2047;
    step(); chk0("clamp_hi", 32'd7867320, 1, 19'd960, 32'd2624440, 1);
    b0.dctrl = 12'sd500;
    step(); chk0("mid", 32'd10490260, 1, 19'd1280, 32'd2622940, 0);

    // Async reset mid-RUN, away from any edge.
    b0.dctrl = '0;
    resetn = 1'b0;
    #1;
    chk0("async_rst", 0, 0, 0, 0, 0);
    #1 resetn = 1'b1;
    settle_seq("s_rst");

    b0.en = 1'b0;
    step(); chk0("en_off", 0, 0, 0, 0, 0);
    b0.en = 1'b1;
    step();
    step(); chk0("abort_e1", 32'd2621440, 0, 19'd320, 32'd2621440, 0);
    b0.en = 1'b0;
    step(); chk0("abort", 0, 0, 0, 0, 0);
    b0.en = 1'b1;
    settle_seq("s_re");

    // Low F0: negative increment floors to 0 and holds the phase.
    b1.en = 1'b1;
    step(); step(); step();
    chk("f0.acc", b1.phase_acc, 200);
    chk("f0.valid", b1.valid, 1);
    b1.dctrl = -12'sd1000;
    step();
    chk("floor.inc", b1.phase_inc, 0);
    chk("floor.sat", b1.sat, 1);
    chk("floor.acc", b1.phase_acc, 200);

    // 8-bit integer accumulator, no settle.
    b2.en = 1'b1;
    step();
    chk("w.e0.valid", b2.valid, 0);
    chk("w.e0.acc", b2.phase_acc, 0);
    step();
    chk("w.e1.acc", b2.phase_acc, 24'd2621440);
    chk("w.e1.valid", b2.valid, 1);
    repeat (6) step();
    chk("w.wrap.acc", b2.phase_acc, 24'd1572864);
    chk("w.wrap.phase", b2.dco_phase, 11'd192);
    chk("w.wrap.valid", b2.valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
